// File: rtl/cnt_gated_sat.sv
// Gated event counter: counts ENABLE while GATE is open, saturates or wraps
// at full scale, and latches the final count/overflow into RESULT at close.
module cnt_gated_sat #(
    parameter int WIDTH = 10,
    parameter int MODE  = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLEAR,
    input  logic             GATE,
    input  logic             ENABLE,
    output logic [WIDTH-1:0] COUNT,
    output logic             FULL,
    output logic             BUSY,
    output logic [WIDTH-1:0] RESULT,
    output logic             RESULT_FULL,
    output logic             DONE
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_d, result_d;
    logic             full_d, rfull_d, done_d;

    always_comb begin
        state_d  = state_q;
        count_d  = COUNT;
        full_d   = FULL;
        result_d = RESULT;
        rfull_d  = RESULT_FULL;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // The event in the window-start cycle is already counted.
                if (GATE) begin
                    state_d = RUN;
                    full_d  = 1'b0;
                    count_d = {{(WIDTH-1){1'b0}}, ENABLE};
                end
            end
            RUN: begin
                if (!GATE) begin
                    state_d  = IDLE;
                    result_d = COUNT;
                    rfull_d  = FULL;
                    done_d   = 1'b1;
                end else if (ENABLE) begin
                    if (COUNT != ALL_ONES) begin
                        count_d = COUNT + 1'b1;
                    end else begin
                        full_d  = 1'b1;
                        count_d = (MODE == 1) ? '0 : COUNT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            COUNT       <= '0;
            FULL        <= 1'b0;
            RESULT      <= '0;
            RESULT_FULL <= 1'b0;
            DONE        <= 1'b0;
        end else if (CLEAR) begin
            // Aborts any open window; the last result is kept.
            state_q <= IDLE;
            COUNT   <= '0;
            FULL    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state_q     <= state_d;
            COUNT       <= count_d;
            FULL        <= full_d;
            RESULT      <= result_d;
            RESULT_FULL <= rfull_d;
            DONE        <= done_d;
        end
    end

    assign BUSY = (state_q == RUN);

endmodule

// File: doc/cnt_gated_sat.md
# cnt_gated_sat

Parametrised gated event counter for the frequency-meter datapath. It counts qualified events (ENABLE) during a measurement window (GATE) and saturates or wraps at full scale, depending on MODE. At window close it latches the final count and overflow status into a result register and pulses DONE for one cycle. It replaces the fixed 10-bit saturating counter and adds windowing, result capture, wrap mode and a synchronous clear.

## Interface
- WIDTH, 10: counter and result width in bits, legal range 2..32.
- MODE, 0: 0 = saturate at all-ones; 1 = wrap to zero.
- CLK  in  1  rising-edge clock, single clock domain.
- RESET  in  1  synchronous, active-high reset.
- CLEAR  in  1  synchronous clear of the live count and FULL. RESULT is not affected.
- GATE  in  1  measurement window, level-sensitive. 1 = window open.
- ENABLE  in  1  event qualifier. Counts one event per cycle when high inside the window.
- COUNT  out  WIDTH  live counter value.
- FULL  out  1  sticky full-scale flag for the current or last window.
- BUSY  out  1  high while state = RUN.
- RESULT  out  WIDTH  count latched at window close.
- RESULT_FULL  out  1  FULL value latched at window close.
- DONE  out  1  one-cycle pulse when RESULT is updated.

## Operation
- State machine has two states, IDLE and RUN. All outputs are registered except BUSY, which decodes the state register.
- Priority per edge: RESET > CLEAR > state-machine action.
- RESET: state = IDLE. COUNT, FULL, RESULT, RESULT_FULL and DONE all go to 0.
- CLEAR: state = IDLE. COUNT, FULL and DONE go to 0. RESULT and RESULT_FULL hold.
- IDLE with GATE=0: COUNT and FULL hold their last values; DONE = 0.
- IDLE with GATE=1 (window start): go to RUN. FULL = 0. COUNT = 1 if ENABLE=1, else 0. The event in the start cycle is counted.
- RUN with GATE=1 and ENABLE=1:
  - If COUNT is below all-ones, COUNT increments by 1.
  - If COUNT is all-ones and MODE=0, COUNT holds and FULL = 1.
  - If COUNT is all-ones and MODE=1, COUNT becomes 0 and FULL = 1.
- RUN with GATE=1 and ENABLE=0: no change.
- RUN with GATE=0 (window end):
  - Go to IDLE.
  - RESULT = COUNT and RESULT_FULL = FULL, using values before this edge.
  - DONE = 1.
  - ENABLE in this cycle is ignored. COUNT and FULL hold.
- DONE is high for exactly one cycle and then returns to 0.
- Once set, FULL stays set until the next window start, CLEAR or RESET.
- In MODE=1, FULL means at least one wrap occurred, so the true count is RESULT + k·2^WIDTH with k ≥ 1.
- GATE held high indefinitely: counting continues. MODE=0 parks at all-ones; MODE=1 keeps wrapping.
- CLEAR during RUN aborts the window: no DONE, no RESULT update.
- Arithmetic is unsigned, modulo 2^WIDTH. There is no carry-out port.

## Timing
- Window start: BUSY=1 in the cycle after GATE is first sampled high.
- Count latency: COUNT reflects an ENABLE sampled at edge N on the output after edge N.
- Window close: DONE, RESULT and RESULT_FULL are valid in the cycle after GATE is first sampled low. BUSY=0 in that same cycle.
- Back-to-back windows:
  - GATE may rise again in the DONE cycle. That edge starts a new window, and DONE falls.
  - The minimum GATE-low time is 1 cycle.
- A window with GATE high for only 1 cycle is legal. RESULT = ENABLE value in the start cycle.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset (WIDTH=4, MODE=0): hold RESET for 2 cycles with GATE=1 and ENABLE=1 → all outputs 0, BUSY=0. After release, the first edge starts a window with COUNT=1.
- Basic window: GATE high for 6 cycles, ENABLE high on cycles 1, 2, 4 and 6 of the window, and ENABLE=1 in the GATE-low cycle → RESULT=4, RESULT_FULL=0, DONE high exactly 1 cycle.
- Saturate (WIDTH=4, MODE=0): GATE high with ENABLE high for 20 cycles → COUNT=15 from cycle 15 onward, FULL=1 from cycle 16, and after close RESULT=15, RESULT_FULL=1.
- Wrap (WIDTH=4, MODE=1): same stimulus → COUNT goes 15 to 0 at cycle 16, FULL=1, RESULT=4, RESULT_FULL=1.
- Back-to-back windows: window A counts 3 events; GATE is low for 1 cycle, then window B counts 5 events → DONE pulses twice, RESULT=3 then 5. Window B starts with FULL cleared.
- CLEAR mid-window: RESULT=7 from a prior window; in the next window, assert CLEAR at COUNT=2 → COUNT=0, BUSY=0, no DONE, RESULT stays 7. GATE still high then starts a fresh window on the following edge.
